graph_mem_port_arbiter: RTL and testbench

// - Shares one read port of graph_memory among NUM_REQ requesters: start-vertex position lookup, graph_fetch port 2, top-k id readout, spare.
// - Replaces the state-based address/valid mux on that port. Arbitration is round-robin; a requester may lock the grant for a multi-word burst (a DIM-word position vector).
// - Holds the requester id of every issued read in an in-order id FIFO and steers each returning word to the requester that issued it.

---
 rtl/graph_mem_port_arbiter_pkg.sv | 18 +
 rtl/graph_mem_port_arbiter_if.sv | 28 ++
 rtl/graph_mem_port_arbiter_rr.sv | 35 +++
 rtl/graph_mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_graph_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/graph_mem_port_arbiter_pkg.sv
// Shared types and constants for the graph_memory read-port arbiter.
// Requester indices name the fixed clients wired to the shared port.
package graph_mem_pkg;

    localparam int N_REQ_DEFAULT     = 4;
    localparam int ADDR_W_DEFAULT    = 32;
    localparam int DATA_W_DEFAULT    = 32;
    localparam int MAX_OUTST_DEFAULT = 4;

    localparam int REQ_ID_W = $clog2(N_REQ_DEFAULT);
    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ_FIRSTPOS = req_id_t'(0);
    localparam req_id_t REQ_FETCH    = req_id_t'(1);
    localparam req_id_t REQ_TOPK     = req_id_t'(2);
    localparam req_id_t REQ_SPARE    = req_id_t'(3);

endpackage

// File: rtl/graph_mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared read port.
// The arbiter takes the slave view; requesters and memory drive the master view.
interface graph_mem_port_arbiter_if #(
    parameter int NUM_REQ = graph_mem_pkg::N_REQ_DEFAULT,
    parameter int ADDR_W  = graph_mem_pkg::ADDR_W_DEFAULT,
    parameter int DATA_W  = graph_mem_pkg::DATA_W_DEFAULT
);
    logic [NUM_REQ-1:0]             req_valid_in;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr_in;
    logic [NUM_REQ-1:0]             req_lock_in;
    logic [NUM_REQ-1:0]             req_ready_out;
    logic [NUM_REQ-1:0]             rsp_valid_out;
    logic [DATA_W-1:0]              rsp_data_out;
    logic [ADDR_W-1:0]              mem_addr_out;
    logic                           mem_valid_out;
    logic [DATA_W-1:0]              mem_data_in;
    logic                           mem_valid_in;

    modport slave (
        input  req_valid_in, req_addr_in, req_lock_in, mem_data_in, mem_valid_in,
        output req_ready_out, rsp_valid_out, rsp_data_out, mem_addr_out, mem_valid_out
    );

    modport master (
        output req_valid_in, req_addr_in, req_lock_in, mem_data_in, mem_valid_in,
        input  req_ready_out, rsp_valid_out, rsp_data_out, mem_addr_out, mem_valid_out
    );
endinterface

// File: rtl/graph_mem_port_arbiter_rr.sv
// Combinational one-hot round-robin grant; a held lock pins the grant
// to its owner regardless of whether the owner is requesting.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    input  logic               locked,
    input  logic [ID_W-1:0]    owner,
    output logic [NUM_REQ-1:0] grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (locked) begin
            grant[owner] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!found && valid[idx[ID_W-1:0]]) begin
                    grant[idx[ID_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/graph_mem_port_arbiter.sv
// Shares one graph_memory read port among NUM_REQ requesters and steers
// in-order read data back to the issuer through a requester-id FIFO.
module graph_mem_port_arbiter
    import graph_mem_pkg::*;
#(
    parameter int NUM_REQ   = N_REQ_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_OUTST = MAX_OUTST_DEFAULT
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    graph_mem_port_arbiter_if.slave   bus,
    output logic [$clog2(MAX_OUTST):0] outst_out,
    output logic                      err_out
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUTST) + 1;

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] beat;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    owner;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    head;
    logic               locked;
    logic               xfer;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   outst;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  rsp_word;
    logic [ID_W-1:0]    id_mem [MAX_OUTST];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid  (bus.req_valid_in),
        .ptr    (rr_ptr),
        .locked (locked),
        .owner  (owner),
        .grant  (grant)
    );

    assign outst      = wr_ptr - rd_ptr;
    assign fifo_full  = (outst == PTR_W'(MAX_OUTST));
    assign fifo_empty = (outst == '0);
    assign outst_out  = outst;

    // Ready is forced low while reset is asserted so every output reads 0 in reset.
    assign bus.req_ready_out = (rst_n_in && !fifo_full) ? grant : '0;
    assign beat = bus.req_valid_in & bus.req_ready_out;
    assign xfer = |beat;
    assign pop  = bus.mem_valid_in && !fifo_empty;
    assign head = id_mem[rd_ptr[PTR_W-2:0]];

    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (beat[i]) winner = ID_W'(i);
        end
    end

    assign win_addr = bus.req_addr_in[winner];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr <= '0;
            owner  <= '0;
            locked <= 1'b0;
        end else if (xfer) begin
            if (bus.req_lock_in[winner]) begin
                owner  <= winner;
                locked <= 1'b1;
            end else begin
                locked <= 1'b0;
                rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus.mem_valid_out <= 1'b0;
            bus.mem_addr_out  <= '0;
        end else begin
            bus.mem_valid_out <= xfer;
            if (xfer) bus.mem_addr_out <= win_addr;
        end
    end

    // Pointers carry one extra bit so full and empty differ without a flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            err_out <= 1'b0;
        end else begin
            if (xfer) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (bus.mem_valid_in && fifo_empty) err_out <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (xfer) id_mem[wr_ptr[PTR_W-2:0]] <= winner;
    end

    always_comb begin
        bus.rsp_valid_out = '0;
        if (pop) bus.rsp_valid_out[head] = 1'b1;
    end

    assign rsp_word         = bus.mem_data_in;
    assign bus.rsp_data_out = rsp_word;

endmodule

// File: tb/tb_graph_mem_port_arbiter.sv
// Directed bench for graph_mem_port_arbiter: single read, contention, burst lock,
// backpressure, bad response and asynchronous reset with reads in flight.
module tb_graph_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] outst;
    logic       err;
    int         total = 0;
    int         bad = 0;

    graph_mem_port_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32)) bus ();

    graph_mem_port_arbiter #(
        .NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)
    ) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .bus       (bus.slave),
        .outst_out (outst),
        .err_out   (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] lock,
                                 input logic mv, input logic [31:0] md);
        bus.req_valid_in = valid;
        bus.req_lock_in  = lock;
        bus.mem_valid_in = mv;
        bus.mem_data_in  = md;
    endtask

    task automatic pulseReset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int exp2[5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp3[4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        int exp4[4] = '{3, 0, 1, 2};

        rst_n = 1'b0;
        applyStimulus(4'b0, 4'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) bus.req_addr_in[i] = '0;
        #12;
        checkOutput("rst_mem_valid", bus.mem_valid_out, 0);
        checkOutput("rst_mem_addr", bus.mem_addr_out, 0);
        checkOutput("rst_outst", outst, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_rsp_valid", bus.rsp_valid_out, 0);
        checkOutput("rst_ready", bus.req_ready_out, 0);
        rst_n = 1'b1;
        tick;

        // single read with memory latency 2
        bus.req_addr_in[0] = 32'h10;
        applyStimulus(4'b0001, 4'b0, 1'b0, 32'h0);
        #1;
        checkOutput("single_ready", bus.req_ready_out, 4'b0001);
        checkOutput("single_no_issue_yet", bus.mem_valid_out, 0);
        tick;
        applyStimulus(4'b0, 4'b0, 1'b0, 32'h0);
        checkOutput("single_mem_valid", bus.mem_valid_out, 1);
        checkOutput("single_mem_addr", bus.mem_addr_out, 32'h10);
        checkOutput("single_outst", outst, 1);
        tick;
        checkOutput("single_mem_valid_drop", bus.mem_valid_out, 0);
        tick;
        applyStimulus(4'b0, 4'b0, 1'b1, 32'hAB);
        #1;
        checkOutput("single_rsp_valid", bus.rsp_valid_out, 4'b0001);
        checkOutput("single_rsp_data", bus.rsp_data_out, 32'hAB);
        tick;
        applyStimulus(4'b0, 4'b0, 1'b0, 32'h0);
        checkOutput("single_outst_done", outst, 0);
        checkOutput("single_err", err, 0);

        // contention from pointer 0, memory answers in the issue cycle
        pulseReset;
        for (int i = 0; i < 4; i++) bus.req_addr_in[i] = 32'h100 + i;
        for (int c = 0; c < 6; c++) begin
            applyStimulus((c < 5) ? 4'hF : 4'h0, 4'h0, c > 0,
                          (c > 0) ? 32'hD0 + c - 1 : 32'h0);
            #1;
            if (c < 5) checkOutput("contend_ready", bus.req_ready_out, oh(exp2[c]));
            if (c > 0) begin
                checkOutput("contend_mem_addr", bus.mem_addr_out, 32'h100 + exp2[c-1]);
                checkOutput("contend_rsp_valid", bus.rsp_valid_out, oh(exp2[c-1]));
                checkOutput("contend_rsp_data", bus.rsp_data_out, 32'hD0 + c - 1);
            end
            tick;
        end
        applyStimulus(4'b0, 4'b0, 1'b0, 32'h0);
        checkOutput("contend_outst", outst, 0);

        // burst lock by req1 while req2 waits
        bus.req_addr_in[1] = 32'h1a;
        bus.req_addr_in[2] = 32'h2a;
        applyStimulus(4'b0110, 4'b0010, 1'b0, 32'h0);
        #1;
        checkOutput("burst_ready0", bus.req_ready_out, 4'b0010);
        tick;
        checkOutput("burst_addr0", bus.mem_addr_out, 32'h1a);
        bus.req_addr_in[1] = 32'h1b;
        #1;
        checkOutput("burst_ready1", bus.req_ready_out, 4'b0010);
        tick;
        checkOutput("burst_addr1", bus.mem_addr_out, 32'h1b);
        bus.req_addr_in[1] = 32'h1c;
        bus.req_lock_in = 4'b0000;
        #1;
        checkOutput("burst_ready2", bus.req_ready_out, 4'b0010);
        tick;
        checkOutput("burst_addr2", bus.mem_addr_out, 32'h1c);
        applyStimulus(4'b0100, 4'b0, 1'b0, 32'h0);
        #1;
        checkOutput("burst_req2_ready", bus.req_ready_out, 4'b0100);
        tick;
        applyStimulus(4'b0, 4'b0, 1'b0, 32'h0);
        checkOutput("burst_req2_addr", bus.mem_addr_out, 32'h2a);
        checkOutput("burst_outst", outst, 4);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0, 4'b0, 1'b1, 32'hE0 + k);
            #1;
            checkOutput("burst_rsp_valid", bus.rsp_valid_out, exp3[k]);
            tick;
        end
        applyStimulus(4'b0, 4'b0, 1'b0, 32'h0);
        checkOutput("burst_drained", outst, 0);

        // backpressure: memory withholds data with all four requesting
        for (int i = 0; i < 4; i++) bus.req_addr_in[i] = 32'h400 + i;
        applyStimulus(4'hF, 4'h0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("bp_ready", bus.req_ready_out, oh(exp4[k]));
            tick;
        end
        checkOutput("bp_outst_full", outst, 4);
        #1;
        checkOutput("bp_ready_low", bus.req_ready_out, 0);
        tick;
        checkOutput("bp_ready_still_low", bus.req_ready_out, 0);
        applyStimulus(4'hF, 4'h0, 1'b1, 32'h55);
        #1;
        checkOutput("bp_rsp_valid", bus.rsp_valid_out, 4'b1000);
        checkOutput("bp_ready_no_bypass", bus.req_ready_out, 0);
        tick;
        applyStimulus(4'hF, 4'h0, 1'b0, 32'h0);
        checkOutput("bp_outst_pop", outst, 3);
        #1;
        checkOutput("bp_ready_after_pop", bus.req_ready_out, 4'b1000);
        tick;
        applyStimulus(4'h0, 4'h0, 1'b0, 32'h0);
        checkOutput("bp_refill_addr", bus.mem_addr_out, 32'h403);
        checkOutput("bp_outst_refull", outst, 4);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'h0, 4'h0, 1'b1, 32'h60 + k);
            #1;
            checkOutput("bp_drain_rsp", bus.rsp_valid_out, oh(k));
            tick;
        end
        applyStimulus(4'h0, 4'h0, 1'b0, 32'h0);
        checkOutput("bp_drained", outst, 0);

        // bad response with the FIFO empty
        applyStimulus(4'h0, 4'h0, 1'b1, 32'h99);
        #1;
        checkOutput("bad_rsp_valid", bus.rsp_valid_out, 0);
        checkOutput("bad_err_before", err, 0);
        tick;
        applyStimulus(4'h0, 4'h0, 1'b0, 32'h0);
        checkOutput("bad_err_set", err, 1);
        checkOutput("bad_outst", outst, 0);
        tick;
        checkOutput("bad_err_sticky", err, 1);

        // asynchronous reset with two reads in flight
        bus.req_addr_in[0] = 32'h600;
        bus.req_addr_in[1] = 32'h601;
        applyStimulus(4'b0011, 4'h0, 1'b0, 32'h0);
        #1;
        checkOutput("rstmid_ready0", bus.req_ready_out, 4'b0001);
        tick;
        #1;
        checkOutput("rstmid_ready1", bus.req_ready_out, 4'b0010);
        tick;
        applyStimulus(4'b0001, 4'h0, 1'b0, 32'h0);
        checkOutput("rstmid_outst", outst, 2);
        checkOutput("rstmid_addr", bus.mem_addr_out, 32'h601);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_mem_valid", bus.mem_valid_out, 0);
        checkOutput("rstmid_mem_addr", bus.mem_addr_out, 0);
        checkOutput("rstmid_outst0", outst, 0);
        checkOutput("rstmid_err", err, 0);
        checkOutput("rstmid_ready", bus.req_ready_out, 0);
        applyStimulus(4'h0, 4'h0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b1;
        tick;
        checkOutput("rstmid_outst_release", outst, 0);
        applyStimulus(4'h0, 4'h0, 1'b1, 32'h77);
        #1;
        checkOutput("rstmid_late_rsp_valid", bus.rsp_valid_out, 0);
        tick;
        applyStimulus(4'h0, 4'h0, 1'b0, 32'h0);
        checkOutput("rstmid_late_err", err, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
